sm_lru_list: RTL
================

Name: sm_lru_list

Overview:
- Parametrised recency tracker for the schoolRISCV top level. Holds up to DEPTH keys, ordered most-recent first, in a shift-register list.
- Succeeds the fixed 8-entry read/write LRU unit. Adds configurable depth, configurable key width, LRU/FIFO policy, remove and flush ops, eviction reporting, and a debug read port in the style of regAddr/regData.
- Sits beside sm_cpu in sm_top. Driven by push/pop-style custom instructions.

Parameters:
DEPTH, 8, number of entries; legal range 2..64
KEY_W, 32, key width in bits
POLICY, 0, 0 = LRU (a hit moves the entry to the front); 1 = FIFO (a hit leaves the order unchanged)
Derived localparams: IDX_W = $clog2(DEPTH); CNT_W = $clog2(DEPTH+1)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
op_valid  in  1  operation strobe; one op accepted per cycle, no backpressure
op_code  in  2  00 touch, 01 remove, 10 flush, 11 no-op
op_key  in  KEY_W  key for touch/remove
rsp_valid  out  1  one-cycle pulse, the cycle after an accepted op
rsp_hit  out  1  op_key matched a valid entry
rsp_pos  out  IDX_W  pre-op index of the matching entry (0 = most recent)
evict_valid  out  1  a touch miss on a full list pushed an entry out
evict_key  out  KEY_W  evicted key
count  out  CNT_W  number of valid entries
full  out  1  count == DEPTH
empty  out  1  count == 0
dbg_idx  in  IDX_W  debug read index
dbg_key  out  KEY_W  key[dbg_idx], combinational
dbg_vld  out  1  dbg_idx < count, combinational

Behaviour:
- Storage: key[0..DEPTH-1] plus count.
  - Valid entries always occupy indices 0..count-1 contiguously.
  - Every slot at index >= count holds key 0.
- Reset (asynchronous, takes effect immediately, including mid-operation):
  - all keys 0, count 0;
  - rsp_valid, rsp_hit, rsp_pos, evict_valid, evict_key all 0;
  - empty = 1, full = 0.
- Match: op_key is compared against valid entries only, in one cycle. The lowest matching index wins; touch never creates duplicates.
- All state and rsp_* outputs update on the clk edge where op_valid = 1. Latency is 1 cycle.
- When op_valid = 0: state holds, rsp_valid = 0, evict_valid = 0. rsp_hit, rsp_pos and evict_key hold their last values and are meaningful only while rsp_valid = 1.
- touch, hit at position p:
  - LRU: key[0] <= op_key; key[1..p] <= old key[0..p-1]; count unchanged.
  - FIFO: no state change.
  - rsp_hit = 1, rsp_pos = p, evict_valid = 0.
- touch, miss, count < DEPTH: key[0] <= op_key, all entries shift down one, count + 1. rsp_hit = 0, rsp_pos = 0, evict_valid = 0.
- touch, miss, count == DEPTH: same shift. Old key[DEPTH-1] drops out: evict_valid = 1, evict_key = old key[DEPTH-1]. count unchanged.
- remove, hit at p:
  - key[p..count-2] <= old key[p+1..count-1];
  - key[count-1] <= 0; count - 1;
  - rsp_hit = 1, rsp_pos = p.
- remove, miss: no state change, rsp_hit = 0, rsp_pos = 0.
- flush: all keys 0, count 0, rsp_hit = 0, rsp_pos = 0, evict_valid = 0. No eviction reporting.
- no-op (11): rsp_valid pulses; no state change; rsp_hit = 0, evict_valid = 0.
- Boundaries:
  - remove on an empty list is a miss;
  - touch of the last-index entry (p = DEPTH-1) on a full list is a hit and never an eviction;
  - count saturates at DEPTH and never wraps.
- full and empty are derived from registered count (no extra lag).

Test Plan:
Use DEPTH=4, KEY_W=8.
1. Reset, then touch 0x11, 0x22, 0x33 -> keys [33,22,11,0]; count = 3; each rsp_hit = 0; empty falls after the first rsp.
2. Touch 0x44, then 0x55 -> after 0x44: full = 1, no evict. On 0x55: evict_valid = 1, evict_key = 0x11; keys [55,44,33,22].
3. POLICY=0, touch 0x33 on [55,44,33,22] -> rsp_hit = 1, rsp_pos = 2; keys [33,55,44,22]. Same stimulus with POLICY=1 -> rsp_hit = 1, rsp_pos = 2, keys unchanged.
4. Remove 0x55 on [33,55,44,22] -> rsp_pos = 1; keys [33,44,22,0]; count = 3; dbg_idx = 3 gives dbg_vld = 0, dbg_key = 0. Remove 0x99 -> rsp_hit = 0, no change.
5. Flush on a full list -> count = 0, empty = 1, all dbg_key = 0. Then remove 0x33 -> miss.
6. Assert rst_n low mid-sequence, asynchronously between edges -> outputs clear before the next clk edge. Back-to-back ops every cycle -> rsp_valid is high every cycle with correct per-op results.

Source files
------------

// File: rtl/sm_lru_list.sv
// Recency tracker: up to DEPTH keys held most-recent first in a shift-register list,
// with touch/remove/flush ops, eviction reporting and a combinational debug read port.
module sm_lru_list #(
    parameter  int DEPTH  = 8,
    parameter  int KEY_W  = 32,
    parameter  int POLICY = 0,
    localparam int IDX_W  = $clog2(DEPTH),
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    // op_valid accepts one op per cycle with no backpressure; rsp_valid pulses for
    // exactly one cycle after each accepted op and rsp_* are meaningful only then.
    input  logic             op_valid,
    input  logic [1:0]       op_code,
    input  logic [KEY_W-1:0] op_key,
    output logic             rsp_valid,
    output logic             rsp_hit,
    output logic [IDX_W-1:0] rsp_pos,
    output logic             evict_valid,
    output logic [KEY_W-1:0] evict_key,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty,
    input  logic [IDX_W-1:0] dbg_idx,
    output logic [KEY_W-1:0] dbg_key,
    output logic             dbg_vld
);

    localparam logic [1:0] OP_TOUCH  = 2'b00;
    localparam logic [1:0] OP_REMOVE = 2'b01;
    localparam logic [1:0] OP_FLUSH  = 2'b10;

    logic [KEY_W-1:0] keyQ [DEPTH];
    logic [KEY_W-1:0] keyD [DEPTH];
    logic [CNT_W-1:0] countD;
    logic             hitD;
    logic [IDX_W-1:0] posD;
    logic             evictD;
    logic [KEY_W-1:0] evictKeyD;

    logic             matchHit;
    logic [IDX_W-1:0] matchPos;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

    // Scanning from the top down lets the lowest matching index win.
    always_comb begin
        matchHit = 1'b0;
        matchPos = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (i < int'(count) && keyQ[i] == op_key) begin
                matchHit = 1'b1;
                matchPos = IDX_W'(i);
            end
        end
    end

    always_comb begin
        keyD      = keyQ;
        countD    = count;
        hitD      = rsp_hit;
        posD      = rsp_pos;
        evictD    = 1'b0;
        evictKeyD = evict_key;
        if (op_valid) begin
            hitD = 1'b0;
            posD = '0;
            case (op_code)
                OP_TOUCH: begin
                    if (matchHit) begin
                        hitD = 1'b1;
                        posD = matchPos;
                        if (POLICY == 0) begin
                            keyD[0] = op_key;
                            for (int i = 1; i < DEPTH; i++) begin
                                if (i <= int'(matchPos)) keyD[i] = keyQ[i-1];
                            end
                        end
                    end else begin
                        // Slots past count are zero, so a full-width shift keeps them zero.
                        keyD[0] = op_key;
                        for (int i = 1; i < DEPTH; i++) keyD[i] = keyQ[i-1];
                        if (full) begin
                            evictD    = 1'b1;
                            evictKeyD = keyQ[DEPTH-1];
                        end else begin
                            countD = count + CNT_W'(1);
                        end
                    end
                end
                OP_REMOVE: begin
                    if (matchHit) begin
                        hitD = 1'b1;
                        posD = matchPos;
                        for (int i = 0; i < DEPTH - 1; i++) begin
                            if (i >= int'(matchPos)) keyD[i] = keyQ[i+1];
                        end
                        keyD[DEPTH-1] = '0;
                        countD = count - CNT_W'(1);
                    end
                end
                OP_FLUSH: begin
                    for (int i = 0; i < DEPTH; i++) keyD[i] = '0;
                    countD = '0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) keyQ[i] <= '0;
            count       <= '0;
            rsp_valid   <= 1'b0;
            rsp_hit     <= 1'b0;
            rsp_pos     <= '0;
            evict_valid <= 1'b0;
            evict_key   <= '0;
        end else begin
            keyQ        <= keyD;
            count       <= countD;
            rsp_valid   <= op_valid;
            rsp_hit     <= hitD;
            rsp_pos     <= posD;
            evict_valid <= evictD;
            evict_key   <= evictKeyD;
        end
    end

    assign dbg_vld = (CNT_W'(dbg_idx) < count);
    assign dbg_key = (int'(dbg_idx) < DEPTH) ? keyQ[dbg_idx] : '0;

endmodule
